// File: rtl/mult_operand_sequencer.sv
// Operand sequencer: buffers signed operand pairs in a small FIFO and steps an
// external enable-controlled multiplier through load, compute and capture.
module mult_operand_sequencer #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MUL_LATENCY = 3,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 busy,
    output logic [WIDTH-1:0]     mulA,
    output logic [WIDTH-1:0]     mulB,
    output logic                 mulEnableA,
    output logic                 mulEnableB,
    output logic                 mulEnableOut,
    output logic                 mulResetA,
    output logic                 mulResetB,
    output logic                 mulResetOut,
    input  logic [2*WIDTH-1:0]   mulProduct
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LAT_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PROD_W-1:0]     fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic                  out_valid_q, out_valid_d;
    logic [PROD_W-1:0]     out_product_q, out_product_d;
    logic [WIDTH-1:0]      mul_a_q, mul_a_d;
    logic [WIDTH-1:0]      mul_b_q, mul_b_d;
    logic                  en_ab_q, en_ab_d;
    logic                  en_out_q, en_out_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic                  push_c;
    logic                  pop_c;
    logic [PROD_W-1:0]     head_c;

    assign push_c = in_valid && in_ready_q;
    assign pop_c  = (state_q == LOAD);
    assign head_c = fifo_q[rd_ptr_q];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, FIFO bookkeeping and next values of all registered outputs
    always_comb begin
        state_d       = state_q;
        lat_d         = lat_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        out_valid_d   = out_valid_q;
        out_product_d = out_product_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

        case (state_q)
            IDLE: begin
                if ((count_q != '0) && (!out_valid_q || out_ready)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = COMPUTE;
                lat_d   = LAT_W'(MUL_LATENCY - 1);
            end
            COMPUTE: begin
                if (lat_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            CAPTURE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A capture in the same cycle as a handshake refills the result slot
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (state_q == CAPTURE) begin
            out_valid_d   = 1'b1;
            out_product_d = mulProduct;
        end

        // Head is stable when entering LOAD: only LOAD pops
        if (state_d == LOAD) begin
            mul_a_d = head_c[PROD_W-1:WIDTH];
            mul_b_d = head_c[WIDTH-1:0];
        end
        en_ab_d    = (state_d == LOAD);
        en_out_d   = (state_d == COMPUTE) || (state_d == CAPTURE);
        in_ready_d = (count_d < CNT_W'(FIFO_DEPTH));
        busy_d     = (state_d != IDLE) || (count_d != '0);
    end

    // Control and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            lat_q         <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            en_ab_q       <= 1'b0;
            en_out_q      <= 1'b0;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            lat_q         <= lat_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            en_ab_q       <= en_ab_d;
            en_out_q      <= en_out_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
        end
    end

    // FIFO storage; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= {in_a, in_b};
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_product  = out_product_q;
    assign busy         = busy_q;
    assign mulA         = mul_a_q;
    assign mulB         = mul_b_q;
    assign mulEnableA   = en_ab_q;
    assign mulEnableB   = en_ab_q;
    assign mulEnableOut = en_out_q;

    // Multiplier resets follow the block reset directly, with no clock delay
    assign mulResetA    = ~reset;
    assign mulResetB    = ~reset;
    assign mulResetOut  = ~reset;

endmodule
